// File: rtl/if_stage_if.sv
// Signal bundle between the instruction-fetch stage, instruction memory and the ID stage.
// Handshake: imem_req/imem_addr are held by the fetch stage until a cycle in which imem_ready=1
// (imem_rdata is valid only in that cycle); a transfer occurs on the rising edge where both are 1.
interface if_stage_if;
    logic        No_Stall;
    logic [1:0]  PCSource;
    logic [31:0] Branch_Addr;
    logic [31:0] Jr_Addr;
    logic [31:0] Jump_Addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] D_Inst;
    logic [31:0] D_Pc4;
    logic        D_Valid;
    logic [5:0]  opCode;
    logic [4:0]  Reg_S;
    logic [4:0]  Reg_T;
    logic [4:0]  Reg_D;
    logic [5:0]  func;
    logic [15:0] Imm;
    logic        dbg_state;

    modport master (
        input  No_Stall, PCSource, Branch_Addr, Jr_Addr, Jump_Addr, imem_rdata, imem_ready,
        output imem_req, imem_addr, D_Inst, D_Pc4, D_Valid, opCode, Reg_S, Reg_T, Reg_D,
               func, Imm, dbg_state
    );

    modport slave (
        output No_Stall, PCSource, Branch_Addr, Jr_Addr, Jump_Addr, imem_rdata, imem_ready,
        input  imem_req, imem_addr, D_Inst, D_Pc4, D_Valid, opCode, Reg_S, Reg_T, Reg_D,
               func, Imm, dbg_state
    );
endinterface

// File: rtl/if_stage.sv
// MIPS-style instruction fetch stage with IF/ID register, one-entry hold buffer and redirect latch.
// Optional macro BRANCH_FLUSH_EN squashes the delay-slot instruction of a taken redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    if_stage_if.master  bus
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic        req_q;
    logic [31:0] pc;
    logic [31:0] d_inst;
    logic [31:0] d_pc4;
    logic        d_valid;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc4;
    logic        hold_valid;
    logic        redir_flag;
    logic [31:0] redir_target;

    logic [31:0] pc_plus4;
    logic [31:0] sel_target;
    logic [31:0] next_pc;
    logic        take_sel;
    logic        complete;
    logic        slot_keep;

    assign pc_plus4 = pc + 32'd4;
    assign take_sel = d_valid & (bus.PCSource != 2'b00);
    assign complete = (state == FETCH) & req_q & bus.imem_ready;

    always_comb begin
        sel_target = pc_plus4;
        case (bus.PCSource)
            2'b01:   sel_target = bus.Branch_Addr;
            2'b10:   sel_target = bus.Jr_Addr;
            2'b11:   sel_target = bus.Jump_Addr;
            default: sel_target = pc_plus4;
        endcase
    end

    // A latched redirect outranks the ID-stage select: by then ID holds a bubble.
    assign next_pc = redir_flag ? redir_target :
                     take_sel   ? sel_target   : pc_plus4;

`ifdef BRANCH_FLUSH_EN
    assign slot_keep = ~(redir_flag | take_sel);
`else
    assign slot_keep = 1'b1;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state        <= FETCH;
            req_q        <= 1'b0;
            pc           <= RESET_PC;
            d_inst       <= 32'd0;
            d_pc4        <= 32'd0;
            d_valid      <= 1'b0;
            hold_inst    <= 32'd0;
            hold_pc4     <= 32'd0;
            hold_valid   <= 1'b0;
            redir_flag   <= 1'b0;
            redir_target <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (complete) begin
                        pc         <= next_pc;
                        redir_flag <= 1'b0;
                        if (bus.No_Stall) begin
                            d_inst  <= slot_keep ? bus.imem_rdata : 32'd0;
                            d_valid <= slot_keep;
                            if (slot_keep) begin
                                d_pc4 <= pc_plus4;
                            end
                        end else begin
                            hold_inst  <= slot_keep ? bus.imem_rdata : 32'd0;
                            hold_pc4   <= pc_plus4;
                            hold_valid <= slot_keep;
                            req_q      <= 1'b0;
                            state      <= HOLD;
                        end
                    end else begin
                        req_q <= 1'b1;
                        if (bus.No_Stall) begin
                            d_inst  <= 32'd0;
                            d_valid <= 1'b0;
                            // The control transfer leaves ID now; remember it for the pending fetch.
                            if (take_sel) begin
                                redir_target <= sel_target;
                                redir_flag   <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (bus.No_Stall) begin
                        d_inst  <= hold_inst;
                        d_valid <= hold_valid;
                        if (hold_valid) begin
                            d_pc4 <= hold_pc4;
                        end
                        req_q   <= 1'b1;
                        state   <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc;
    assign bus.D_Inst    = d_inst;
    assign bus.D_Pc4     = d_pc4;
    assign bus.D_Valid   = d_valid;
    assign bus.opCode    = d_inst[31:26];
    assign bus.Reg_S     = d_inst[25:21];
    assign bus.Reg_T     = d_inst[20:16];
    assign bus.Reg_D     = d_inst[15:11];
    assign bus.func      = d_inst[5:0];
    assign bus.Imm       = d_inst[15:0];
    assign bus.dbg_state = (state == HOLD);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand sequences for multi-cycle corners,
// and a randomized run against a program-flow model (fetch order, delay slots, ID queue).
module tb_if_stage;

    logic clk;
    logic clrn;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BRANCH_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ready;
        logic        ns;
        logic [1:0]  pcs;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vecs[14];

    // Random-phase model state
    logic [63:0] exp_q[$];
    logic [31:0] m_pc, m_tgt, e_inst, e_pc4, a_id, fa;
    logic        m_req, m_hold, m_pend, e_valid, r_in, n_in, was_slot;
    logic [63:0] ent;
    int          completions;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic n, input logic [1:0] p,
                                input logic [31:0] d, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.ready = r; v.ns = n; v.pcs = p; v.rdata = d;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_inst = ei; v.exp_pc4 = ep;
        return v;
    endfunction

    function automatic logic [31:0] w_of(input logic [31:0] a);
        return 32'h8C22_0000 | (a & 32'h0000_FFFF);
    endfunction

    function automatic logic is_br(input logic [31:0] a);
        return a[5:2] == 4'd7;
    endfunction

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return {is_br(a) ? 6'h04 : 6'h23, a[27:2]};
    endfunction

    function automatic logic [1:0] kind_of(input logic [31:0] a);
        return (a[7:6] == 2'b00) ? 2'b01 : a[7:6];
    endfunction

    function automatic logic [31:0] btgt(input logic [31:0] a);
        return (a + 32'h124) & 32'h0000_0FFC;
    endfunction

    function automatic logic [31:0] rtgt(input logic [31:0] a);
        return (a ^ 32'h5A0) & 32'h0000_0FFC;
    endfunction

    function automatic logic [31:0] jtgt(input logic [31:0] a);
        return ((a << 1) + 32'h38) & 32'h0000_0FFC;
    endfunction

    function automatic logic [31:0] tgt_of(input logic [31:0] a);
        case (kind_of(a))
            2'b01:   return btgt(a);
            2'b10:   return rtgt(a);
            default: return jtgt(a);
        endcase
    endfunction

    task automatic drive_idle();
        bus.No_Stall    = 1'b0;
        bus.PCSource    = 2'b00;
        bus.imem_rdata  = 32'd0;
        bus.imem_ready  = 1'b0;
        bus.Branch_Addr = 32'h40;
        bus.Jr_Addr     = 32'h80;
        bus.Jump_Addr   = 32'h100;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic step(input logic r, input logic n, input logic [1:0] p, input logic [31:0] d);
        bus.imem_ready = r;
        bus.No_Stall   = n;
        bus.PCSource   = p;
        bus.imem_rdata = d;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"},   bus.imem_req, 32'd0);
        chk({tag, " addr"},  bus.imem_addr, 32'h0);
        chk({tag, " inst"},  bus.D_Inst, 32'd0);
        chk({tag, " pc4"},   bus.D_Pc4, 32'd0);
        chk({tag, " valid"}, bus.D_Valid, 32'd0);
        chk({tag, " state"}, bus.dbg_state, 32'd0);
    endtask

    initial begin
        clrn = 1'b1;
        drive_idle();
        #1 clrn = 1'b0;
        #1 chk_reset_outputs("reset");

        // ---------------- table-driven sequence from reset ----------------
        vecs[0]  = mk(1, 1, 2'b00, w_of(0),     1, 32'h0,   0, 32'd0,      32'h0);
        vecs[1]  = mk(1, 1, 2'b00, w_of(0),     1, 32'h4,   1, w_of(0),    32'h4);
        vecs[2]  = mk(1, 1, 2'b00, w_of(4),     1, 32'h8,   1, w_of(4),    32'h8);
        vecs[3]  = mk(0, 1, 2'b00, 32'd0,       1, 32'h8,   0, 32'd0,      32'h8);
        vecs[4]  = mk(0, 1, 2'b00, 32'd0,       1, 32'h8,   0, 32'd0,      32'h8);
        vecs[5]  = mk(0, 1, 2'b00, 32'd0,       1, 32'h8,   0, 32'd0,      32'h8);
        vecs[6]  = mk(1, 1, 2'b00, w_of(8),     1, 32'hC,   1, w_of(8),    32'hC);
        vecs[7]  = mk(1, 1, 2'b00, w_of(12),    1, 32'h10,  1, w_of(12),   32'h10);
        vecs[8]  = mk(1, 0, 2'b00, w_of(16),    0, 32'h14,  1, w_of(12),   32'h10);
        vecs[9]  = mk(0, 0, 2'b00, 32'd0,       0, 32'h14,  1, w_of(12),   32'h10);
        vecs[10] = mk(0, 1, 2'b00, 32'd0,       1, 32'h14,  1, w_of(16),   32'h14);
        vecs[11] = mk(0, 1, 2'b11, 32'd0,       1, 32'h14,  0, 32'd0,      32'h14);
        vecs[12] = mk(1, 1, 2'b00, w_of(20),    1, 32'h100, !FLUSH,
                      FLUSH ? 32'd0 : w_of(20), FLUSH ? 32'h14 : 32'h18);
        vecs[13] = mk(1, 1, 2'b00, w_of(32'h100), 1, 32'h104, 1, w_of(32'h100), 32'h104);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].ready, vecs[i].ns, vecs[i].pcs, vecs[i].rdata);
            chk($sformatf("row%0d req", i), bus.imem_req, vecs[i].exp_req);
            chk($sformatf("row%0d addr", i), bus.imem_addr, vecs[i].exp_addr);
            chk($sformatf("row%0d valid", i), bus.D_Valid, vecs[i].exp_valid);
            chk($sformatf("row%0d inst", i), bus.D_Inst, vecs[i].exp_inst);
            chk($sformatf("row%0d pc4", i), bus.D_Pc4, vecs[i].exp_pc4);
            chk($sformatf("row%0d opcode", i), bus.opCode, vecs[i].exp_inst[31:26]);
            chk($sformatf("row%0d imm", i), bus.Imm, vecs[i].exp_inst[15:0]);
        end

        // ---------------- branch in ID while fetch of 0x8 completes ----------------
        do_reset();
        step(1, 1, 2'b00, 32'd0);
        step(1, 1, 2'b00, w_of(0));
        step(1, 1, 2'b00, 32'h1000_0010);
        chk("beq in id", bus.D_Inst, 32'h1000_0010);
        step(1, 1, 2'b01, w_of(8));
        chk("beq target addr", bus.imem_addr, 32'h40);
        chk("beq slot valid", bus.D_Valid, !FLUSH);
        chk("beq slot inst", bus.D_Inst, FLUSH ? 32'd0 : w_of(8));
        step(1, 1, 2'b00, w_of(32'h40));
        chk("beq after addr", bus.imem_addr, 32'h44);
        chk("beq after inst", bus.D_Inst, w_of(32'h40));
        chk("beq after pc4", bus.D_Pc4, 32'h44);

        // ---------------- 32-bit PC wrap ----------------
        do_reset();
        step(1, 1, 2'b00, 32'd0);
        step(1, 1, 2'b00, 32'h0800_0040);
        bus.Jump_Addr = 32'hFFFF_FFFC;
        step(1, 1, 2'b11, w_of(4));
        chk("wrap jump addr", bus.imem_addr, 32'hFFFF_FFFC);
        step(1, 1, 2'b00, 32'h2400_0001);
        chk("wrap addr", bus.imem_addr, 32'h0);
        chk("wrap pc4", bus.D_Pc4, 32'h0);
        chk("wrap valid", bus.D_Valid, 32'd1);

        // ---------------- reset pulsed mid-HOLD ----------------
        do_reset();
        step(1, 1, 2'b00, 32'd0);
        step(1, 1, 2'b00, w_of(0));
        step(1, 0, 2'b00, w_of(4));
        chk("hold entered", bus.dbg_state, 32'd1);
        chk("hold req", bus.imem_req, 32'd0);
        #2 clrn = 1'b0;
        #1 chk_reset_outputs("async reset");
        @(negedge clk);
        bus.imem_ready = 1'b0;
        clrn = 1'b1;
        #1 chk("release req low", bus.imem_req, 32'd0);
        @(negedge clk);
        chk("release req", bus.imem_req, 32'd1);
        chk("release addr", bus.imem_addr, 32'h0);
        chk("release valid", bus.D_Valid, 32'd0);

        // ---------------- randomized run against program-flow model ----------------
        do_reset();
        m_pc = 32'h0; m_req = 1'b0; m_hold = 1'b0; m_pend = 1'b0; m_tgt = 32'd0;
        e_inst = 32'd0; e_pc4 = 32'd0; e_valid = 1'b0; completions = 0;
        exp_q.delete();
        for (int i = 0; i < 2500; i++) begin
            r_in = ($urandom_range(0, 99) < 60);
            n_in = ($urandom_range(0, 99) < 70);
            a_id = bus.D_Pc4 - 32'd4;
            bus.Branch_Addr = btgt(a_id);
            bus.Jr_Addr     = rtgt(a_id);
            bus.Jump_Addr   = jtgt(a_id);
            bus.PCSource    = (bus.D_Valid && bus.D_Inst[31:26] == 6'h04) ? kind_of(a_id) : 2'b00;
            bus.imem_rdata  = mem_of(bus.imem_addr);
            bus.imem_ready  = r_in;
            bus.No_Stall    = n_in;
            @(negedge clk);

            if (m_req && r_in) begin
                completions++;
                fa = m_pc;
                was_slot = m_pend;
                if (!(FLUSH && was_slot)) exp_q.push_back({mem_of(fa), fa + 32'd4});
                if (m_pend) begin
                    m_pc = m_tgt;
                    m_pend = 1'b0;
                end else begin
                    m_pc = fa + 32'd4;
                end
                if (is_br(fa)) begin
                    m_pend = 1'b1;
                    m_tgt = tgt_of(fa);
                end
                if (!n_in) begin
                    m_req = 1'b0;
                    m_hold = 1'b1;
                end
            end else if (!m_req) begin
                if (!m_hold) m_req = 1'b1;
                else if (n_in) begin
                    m_req = 1'b1;
                    m_hold = 1'b0;
                end
            end
            if (n_in) begin
                if (exp_q.size() > 0) begin
                    ent = exp_q.pop_front();
                    e_inst = ent[63:32];
                    e_pc4 = ent[31:0];
                    e_valid = 1'b1;
                end else begin
                    e_inst = 32'd0;
                    e_valid = 1'b0;
                end
            end

            chk("rnd req", bus.imem_req, m_req);
            if (m_req) chk("rnd addr", bus.imem_addr, m_pc);
            chk("rnd valid", bus.D_Valid, e_valid);
            chk("rnd inst", bus.D_Inst, e_inst);
            chk("rnd pc4", bus.D_Pc4, e_pc4);
            chk("rnd opcode", bus.opCode, e_inst[31:26]);
            chk("rnd reg_s", bus.Reg_S, e_inst[25:21]);
            chk("rnd reg_t", bus.Reg_T, e_inst[20:16]);
            chk("rnd reg_d", bus.Reg_D, e_inst[15:11]);
            chk("rnd func", bus.func, e_inst[5:0]);
            chk("rnd imm", bus.Imm, e_inst[15:0]);
        end
        chk("rnd progress", (completions >= 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports are listed below as name, direction, width, meaning.
- clk  input  1  rising-edge clock.
- clrn  input  1  asynchronous active-low reset.
- No_Stall  input  1  ID stage may advance; a low value holds IF/ID.
- PCSource  input  2  next-PC select for the instruction in ID: 00 = pc+4, 01 = branch, 10 = jr, 11 = jump.
- Branch_Addr  input  32  branch target.
- Jr_Addr  input  32  register target.
- Jump_Addr  input  32  jump target.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address.
- imem_rdata  input  32  fetched word.
- imem_ready  input  1  rdata valid this cycle.
- D_Inst  output  32  IF/ID instruction.
- D_Pc4  output  32  IF/ID pc+4.
- D_Valid  output  1  IF/ID holds a real instruction.
- opCode  output  6  D_Inst[31:26].
- Reg_S  output  5  D_Inst[25:21].
- Reg_T  output  5  D_Inst[20:16].
- Reg_D  output  5  D_Inst[15:11].
- func  output  6  D_Inst[5:0].
- Imm  output  16  D_Inst[15:0].

Function
REQ-003 SHALL implement the FSM states FETCH and HOLD.
REQ-004 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the PC register; the address SHALL stay stable until imem_ready.
REQ-005 A fetch completes when FETCH & imem_ready; completion SHALL take zero extra cycles, with D updating at the same clock edge.
REQ-006 Completion with No_Stall=1 SHALL load D_Inst with rdata, D_Pc4 with PC+4, D_Valid with 1, and the PC with next_pc; the FSM SHALL stay in FETCH.
REQ-007 Completion with No_Stall=0 SHALL capture rdata into a one-entry hold buffer, advance the PC to next_pc, leave D unchanged, and move to HOLD.
REQ-008 In HOLD, imem_req SHALL be 0; when No_Stall=1, D SHALL load from the hold buffer with D_Valid=1 and the FSM SHALL return to FETCH.
REQ-009 When FETCH, ~imem_ready and No_Stall=1, D SHALL load a bubble: D_Inst=0, D_Valid=0, D_Pc4 unchanged.
REQ-010 next_pc SHALL be selected as follows:
- the latched redirect target if the redirect flag is set;
- otherwise the PCSource-selected target if D_Valid & PCSource!=00;
- otherwise PC+4.
REQ-011 If D_Valid & PCSource!=00 & No_Stall=1 and the fetch does not complete that cycle, the selected target SHALL be latched and the redirect flag set; the flag SHALL clear on the next completion.
REQ-012 When No_Stall=0, D SHALL hold all fields, and PCSource SHALL continue to be honoured at completion.
REQ-013 PC arithmetic SHALL be 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
REQ-014 Field outputs SHALL be pure combinational slices of D_Inst.

Reset
REQ-015 While clrn=0, and asynchronously on its falling edge, the following SHALL hold:
- PC = RESET_PC;
- D_Inst = 0, D_Pc4 = 0, D_Valid = 0;
- hold buffer and redirect flag cleared;
- FSM = FETCH;
- imem_req = 0.
REQ-016 Reset mid-fetch SHALL abandon the request; the first request after release SHALL be to RESET_PC on the first clk edge after clrn rises.

Configuration
REQ-017 Macro BRANCH_FLUSH_EN: when defined, a completion that uses a non-pc+4 next_pc SHALL load D as a bubble (D_Valid=0, D_Inst=0), squashing the delay slot.
REQ-018 When BRANCH_FLUSH_EN is undefined, the delay-slot instruction SHALL enter ID with D_Valid=1 (MIPS delay-slot semantics).

Verification
REQ-019 Reset release with imem_ready=1 constant and PCSource=00 -> imem_addr is 0, 4, 8 on successive cycles; D_Pc4 is 4, 8, 12 one cycle after each.
REQ-020 imem_ready low for 3 cycles at addr 0x8 -> imem_addr is held at 0x8 and D_Valid=0 for 3 cycles, then D_Inst=rdata and D_Pc4=0xC.
REQ-021 D holds beq, PCSource=01, Branch_Addr=0x40, fetch of 0x8 completes -> next imem_addr=0x40; D_Valid=1 when the macro is undefined, D_Valid=0 when it is defined.
REQ-022 No_Stall=0 when the fetch of 0x10 completes -> HOLD, imem_req=0, D unchanged; after No_Stall rises, D_Inst=buffered word and imem_addr=0x14.
REQ-023 Jump (PCSource=11, Jump_Addr=0x100) leaves ID while the fetch is pending -> on completion, next imem_addr=0x100.
REQ-024 clrn pulsed low mid-HOLD -> all outputs take their reset values immediately; after release, imem_addr=RESET_PC.
